// File: rtl/raiz_arbitro.sv
// raiz_arbitro: round-robin arbiter sharing one square-root unit between two requesters.
// Defining RAIZ_TIMEOUT_EN adds a TIMEOUT_CICLOS watchdog on the ESPERAR state.
module raiz_arbitro #(
  parameter int TIMEOUT_CICLOS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] radicando0,
  input  logic [15:0] radicando1,
  output logic        hecho0,
  output logic        hecho1,
  output logic [15:0] res0,
  output logic [15:0] res1,
  output logic        error0,
  output logic        error1,
  output logic        ocupado,
  output logic        iniciar,
  output logic [15:0] radicando,
  input  logic [15:0] raiz_res,
  input  logic        terminado
);

  typedef enum logic [1:0] {
    IDLE,
    LANZAR,
    ESPERAR,
    ENTREGAR
  } estado_t;

  estado_t     estado;
  estado_t     sig;
  logic        gnt;
  logic        ultimo;
  logic        ganador;
  logic        hay_req;
  logic        term_q;
  logic        flanco;
  logic        fin;
  logic [15:0] res0_q;
  logic [15:0] res1_q;
  logic [15:0] rad_q;
  logic [15:0] dato;

  assign hay_req = req0 | req1;
  // ultimo is the index served last; on contention the other one wins
  assign ganador = (req0 & req1) ? ~ultimo : req1;
  assign flanco  = (estado == ESPERAR) & terminado & ~term_q;

`ifdef RAIZ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  logic [CW-1:0] cnt;
  logic          err_q;
  logic          vence;

  assign vence = (estado == ESPERAR) &
                 (cnt == CW'(TIMEOUT_CICLOS - 1));
  // a real completion in the timeout cycle takes precedence
  assign fin   = flanco | vence;
  assign dato  = flanco ? raiz_res : 16'hFFFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (estado == ESPERAR) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (fin) begin
      err_q <= ~flanco;
    end
  end

  assign error0 = hecho0 & err_q;
  assign error1 = hecho1 & err_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CICLOS;
  assign fin        = flanco;
  assign dato       = raiz_res;
  assign error0     = 1'b0;
  assign error1     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
    end else begin
      estado <= sig;
    end
  end

  always_comb begin
    sig = estado;
    unique case (estado)
      IDLE:     if (hay_req) sig = LANZAR;
      LANZAR:   sig = ESPERAR;
      ESPERAR:  if (fin) sig = ENTREGAR;
      ENTREGAR: sig = IDLE;
      default:  sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= 1'b0;
      ultimo <= 1'b1;
      term_q <= 1'b0;
      rad_q  <= '0;
      res0_q <= '0;
      res1_q <= '0;
    end else begin
      term_q <= terminado;
      if (estado == IDLE && hay_req) begin
        gnt    <= ganador;
        ultimo <= ganador;
        rad_q  <= ganador ? radicando1 : radicando0;
      end
      if (fin) begin
        if (gnt) res1_q <= dato;
        else     res0_q <= dato;
      end
    end
  end

  assign hecho0    = (estado == ENTREGAR) & ~gnt;
  assign hecho1    = (estado == ENTREGAR) & gnt;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign ocupado   = (estado != IDLE);
  assign iniciar   = (estado == LANZAR);
  assign radicando = rad_q;

endmodule

// File: tb/tb_raiz_arbitro.sv
// tb_raiz_arbitro: randomized bench for raiz_arbitro with a behavioural sqrt unit.
// Reference results come from an arithmetic integer square root.
module tb_raiz_arbitro;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] radicando0 = '0;
  logic [15:0] radicando1 = '0;
  logic        hecho0, hecho1, error0, error1;
  logic [15:0] res0, res1, radicando;
  logic        ocupado, iniciar;
  logic [15:0] raiz_res = '0;
  logic        terminado = 1'b0;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  raiz_arbitro #(.TIMEOUT_CICLOS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .radicando0(radicando0), .radicando1(radicando1),
    .hecho0(hecho0), .hecho1(hecho1),
    .res0(res0), .res1(res1),
    .error0(error0), .error1(error1),
    .ocupado(ocupado), .iniciar(iniciar),
    .radicando(radicando),
    .raiz_res(raiz_res), .terminado(terminado)
  );

  function automatic logic [15:0] isqrt(input logic [15:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 16'(r);
  endfunction

  // sqrt unit: keeps terminado high between ops, drops it late, raises it later
  bit          mute = 0;
  int          extra = 0;
  bit          busy = 0;
  int          k, drop_at, rise_at, d;
  logic [15:0] op_u;

  always @(posedge clk) begin
    if (mute) begin
      terminado <= 1'b0;
      busy <= 0;
    end else if (iniciar) begin
      d = $urandom_range(1, 3);
      busy <= 1;
      k <= 1;
      op_u <= radicando;
      drop_at <= d;
      rise_at <= d + int'($urandom_range(1, 4)) + extra;
    end else if (busy) begin
      k <= k + 1;
      if (k == drop_at) terminado <= 1'b0;
      if (k == rise_at) begin
        terminado <= 1'b1;
        raiz_res <= isqrt(op_u);
        busy <= 0;
      end
    end
  end

  int          n_ini = 0, n_h0 = 0, n_h1 = 0;
  logic [15:0] ult_lanzado = '0;
  logic [15:0] last_res [2];

  always @(negedge clk) begin
    if (iniciar) begin
      n_ini++;
      ult_lanzado = radicando;
    end
    if (hecho0) n_h0++;
    if (hecho1) n_h1++;
  end

  task automatic set_req(input int n, input logic r, input logic [15:0] v);
    if (n == 0) begin
      req0 = r;
      radicando0 = v;
    end else begin
      req1 = r;
      radicando1 = v;
    end
  endtask

  task automatic wait_hecho(input int n, input int budget, output bit got);
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if ((n == 0) ? hecho0 : hecho1) got = 1;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    mute = 0;
    extra = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    nchk++;
    if ({ocupado, iniciar, hecho0, hecho1, error0, error1} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_flags got=%b exp=000000",
               {ocupado, iniciar, hecho0, hecho1, error0, error1});
    end
    nchk++;
    if (res0 !== 16'h0) begin
      nerr++; $display("FAIL reset_res0 got=%h exp=0000", res0);
    end
    nchk++;
    if (res1 !== 16'h0) begin
      nerr++; $display("FAIL reset_res1 got=%h exp=0000", res1);
    end
    nchk++;
    if (radicando !== 16'h0) begin
      nerr++; $display("FAIL reset_rad got=%h exp=0000", radicando);
    end
  endtask

  task automatic test_single;
    bit got;
    int h1, idx, idx_rise, idx_h;
    logic tprev;
    do_reset();
    h1 = n_h1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'd144);
    @(negedge clk);
    nchk++;
    if (iniciar !== 1'b0) begin
      nerr++; $display("FAIL lat_early got=%b exp=0", iniciar);
    end
    @(negedge clk);
    nchk++;
    if ({iniciar, radicando} !== {1'b1, 16'd144}) begin
      nerr++;
      $display("FAIL lanzar got=%b/%0d exp=1/144", iniciar, radicando);
    end
    idx = 0; idx_rise = -1; idx_h = -1; tprev = terminado;
    for (int c = 0; c < 100 && idx_h < 0; c++) begin
      @(negedge clk);
      idx++;
      if (terminado && !tprev && idx_rise < 0) idx_rise = idx;
      tprev = terminado;
      if (hecho0) idx_h = idx;
    end
    nchk++;
    if (idx_h < 0 || idx_h != idx_rise + 1) begin
      nerr++;
      $display("FAIL done_lat got=%0d exp=%0d", idx_h, idx_rise + 1);
    end
    nchk++;
    if ({res0, error0} !== {16'd12, 1'b0}) begin
      nerr++; $display("FAIL single_res got=%0d/%b exp=12/0", res0, error0);
    end
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    nchk++;
    if (n_h1 !== h1) begin
      nerr++; $display("FAIL single_h1 got=%0d exp=%0d", n_h1, h1);
    end
  endtask

  task automatic test_both;
    bit got;
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'd144);
    set_req(1, 1'b1, 16'd2);
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (hecho0 || hecho1) got = 1;
    end
    nchk++;
    if ({hecho0, hecho1, res0} !== {1'b1, 1'b0, 16'd12}) begin
      nerr++;
      $display("FAIL both_first got=%b%b/%0d exp=10/12", hecho0, hecho1, res0);
    end
    req0 = 1'b0;
    @(negedge clk);
    nchk++;
    if (ocupado !== 1'b0) begin
      nerr++; $display("FAIL idle_gap got=%b exp=0", ocupado);
    end
    wait_hecho(1, 100, got);
    nchk++;
    if ({got, res1, res0} !== {1'b1, 16'd1, 16'd12}) begin
      nerr++;
      $display("FAIL both_second got=%b/%0d/%0d exp=1/1/12", got, res1, res0);
    end
    req1 = 1'b0;
  endtask

  task automatic test_alternate;
    logic [15:0] v0, v1;
    logic        exp_who, who;
    bit          got;
    do_reset();
    v0 = 16'($urandom);
    v1 = 16'($urandom);
    @(posedge clk); #1;
    set_req(0, 1'b1, v0);
    set_req(1, 1'b1, v1);
    exp_who = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (hecho0 || hecho1) got = 1;
      end
      who = hecho1;
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      nchk++;
      if ({got, who} !== {1'b1, exp_who}) begin
        nerr++;
        $display("FAIL alt_order op=%0d got=%b/%b exp=1/%b", i, got, who, exp_who);
      end
      nchk++;
      if ((who ? res1 : res0) !== isqrt(who ? v1 : v0)) begin
        nerr++;
        $display("FAIL alt_res op=%0d got=%0d exp=%0d",
                 i, who ? res1 : res0, isqrt(who ? v1 : v0));
      end
      exp_who = ~exp_who;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_drop;
    bit got;
    int ini0, h1;
    do_reset();
    extra = 12;
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'd100);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ocupado) got = 1;
    end
    @(negedge clk); #1;
    ini0 = n_ini;
    h1 = n_h1;
    req0 = 1'b0;
    set_req(1, 1'b1, 16'd55);
    repeat (2) @(posedge clk);
    #1 req1 = 1'b0;
    wait_hecho(0, 100, got);
    nchk++;
    if ({got, res0} !== {1'b1, 16'd10}) begin
      nerr++; $display("FAIL drop_h0 got=%b/%0d exp=1/10", got, res0);
    end
    extra = 0;
    repeat (20) @(negedge clk);
    #1;
    nchk++;
    if ({n_ini, n_h1} !== {ini0, h1}) begin
      nerr++;
      $display("FAIL drop_req1 got=%0d/%0d exp=%0d/%0d", n_ini, n_h1, ini0, h1);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    int h0;
    do_reset();
    mute = 1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'd144);
    repeat (5) @(negedge clk);
    #1;
    h0 = n_h0;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({ocupado, iniciar, hecho0, error0, radicando, res0} !== '0) begin
      nerr++;
      $display("FAIL mid_reset got=%b%b%b%b/%h/%h exp=0", ocupado, iniciar,
               hecho0, error0, radicando, res0);
    end
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mute = 0;
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if (n_h0 !== h0) begin
      nerr++; $display("FAIL mid_no_hecho got=%0d exp=%0d", n_h0, h0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'd16);
    wait_hecho(0, 100, got);
    nchk++;
    if ({got, res0} !== {1'b1, 16'd4}) begin
      nerr++; $display("FAIL mid_after got=%b/%0d exp=1/4", got, res0);
    end
    req0 = 1'b0;
  endtask

  task automatic test_timeout;
    bit got;
    do_reset();
    mute = 1;
    @(posedge clk); #1;
    set_req(1, 1'b1, 16'd9);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (iniciar) got = 1;
    end
    nchk++;
    if (got !== 1'b1) begin
      nerr++; $display("FAIL to_lanzar got=0 exp=1");
    end
`ifdef RAIZ_TIMEOUT_EN
    begin
      int c;
      c = 0;
      got = 0;
      while (c < 200 && !got) begin
        @(negedge clk);
        c++;
        if (hecho1) got = 1;
      end
      nchk++;
      if ({got, c} !== {1'b1, 32'd65}) begin
        nerr++; $display("FAIL to_latency got=%b/%0d exp=1/65", got, c);
      end
      nchk++;
      if ({error1, res1} !== {1'b1, 16'hFFFF}) begin
        nerr++; $display("FAIL to_result got=%b/%h exp=1/ffff", error1, res1);
      end
    end
`else
    begin
      int h1;
      h1 = n_h1;
      repeat (150) @(negedge clk);
      #1;
      nchk++;
      if ({n_h1, ocupado} !== {h1, 1'b1}) begin
        nerr++;
        $display("FAIL to_wait got=%0d/%b exp=%0d/1", n_h1, ocupado, h1);
      end
    end
`endif
    req1 = 1'b0;
    mute = 0;
  endtask

  task automatic requester(input int n, input int ops);
    logic [15:0] op;
    logic [15:0] r, ro;
    bit          got;
    for (int i = 0; i < ops; i++) begin
      op = 16'($urandom);
      set_req(n, 1'b1, op);
      wait_hecho(n, 400, got);
      if (!got) begin
        nchk++; nerr++;
        $display("FAIL rnd_timeout req=%0d got=none exp=hecho", n);
        set_req(n, 1'b0, op);
        break;
      end
      r  = (n == 0) ? res0 : res1;
      ro = (n == 0) ? res1 : res0;
      nchk++;
      if (r !== isqrt(op)) begin
        nerr++;
        $display("FAIL rnd_res req=%0d op=%0d got=%0d exp=%0d", n, op, r, isqrt(op));
      end
      nchk++;
      if (((n == 0) ? error0 : error1) !== 1'b0) begin
        nerr++; $display("FAIL rnd_err req=%0d got=1 exp=0", n);
      end
      nchk++;
      if (ult_lanzado !== op) begin
        nerr++;
        $display("FAIL rnd_issue req=%0d got=%0d exp=%0d", n, ult_lanzado, op);
      end
      nchk++;
      if (ro !== last_res[1 - n]) begin
        nerr++;
        $display("FAIL rnd_other req=%0d got=%0d exp=%0d", n, ro, last_res[1 - n]);
      end
      last_res[n] = r;
      set_req(n, 1'b0, op);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random;
    do_reset();
    last_res[0] = '0;
    last_res[1] = '0;
    fork
      requester(0, 8);
      requester(1, 8);
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_alternate();
    test_drop();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
